// File: rtl/adam_clk_div_prog.sv
// -----------------------------------------------------------------------------
// adam_clk_div_prog
//   Runtime-programmable clock divider. It produces a registered divided clock
//   (o_out) and a one-cycle strobe (o_tick) that is high in every cycle where
//   o_out rises. The ratio is loaded over a valid/ready port. While running,
//   a new ratio is held in a pending slot and takes effect only at a period
//   boundary, so o_out never shows a runt pulse.
//
// Parameters
//   WIDTH      width of ratio, counter and status; max ratio 2**WIDTH-1
//   RESET_DIV  ratio in effect after reset (>= 2, < 2**WIDTH)
//
// Ports
//   i_clk          system clock, all logic on its rising edge
//   i_rst          asynchronous active-high reset
//   i_en           run request; a stop takes effect at the end of a period
//   i_div          requested ratio D (0 and 1 are clamped to 2)
//   i_div_valid    i_div is valid
//   o_div_ready    a ratio can be accepted (no ratio is pending)
//   o_div_active   effective ratio E currently in use
//   o_out          divided clock: high for H=(E+1)>>1 cycles, low for E-H
//   o_tick         one-cycle pulse in the cycle o_out rises
// -----------------------------------------------------------------------------
module adam_clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  output logic [WIDTH-1:0] o_div_active,
  output logic             o_out,
  output logic             o_tick
);

  localparam logic [WIDTH-1:0] RESET_E = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] MIN_E   = WIDTH'(2);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_div_active;
  logic [WIDTH-1:0] w_div_active_next;
  logic [WIDTH-1:0] r_pend_val;
  logic [WIDTH-1:0] w_pend_val_next;
  logic             r_pending;
  logic             w_pending_next;
  logic             r_out;
  logic             w_out_next;
  logic             r_tick;
  logic             w_tick_next;

  logic [WIDTH-1:0] w_div_clamped;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH:0]   w_half;
  logic             w_xfer;
  logic             w_boundary;

  assign w_div_clamped = (i_div < MIN_E) ? MIN_E : i_div;
  // One extra bit so E = 2**WIDTH-1 does not wrap when adding 1.
  assign w_half        = ({1'b0, r_div_active} + (WIDTH+1)'(1)) >> 1;
  assign w_cnt_inc     = r_cnt + WIDTH'(1);
  assign w_xfer        = i_div_valid && !r_pending;
  assign w_boundary    = (r_cnt == (r_div_active - WIDTH'(1)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_STOP;
      r_cnt        <= '0;
      r_div_active <= RESET_E;
      r_pend_val   <= '0;
      r_pending    <= 1'b0;
      r_out        <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_div_active <= w_div_active_next;
      r_pend_val   <= w_pend_val_next;
      r_pending    <= w_pending_next;
      r_out        <= w_out_next;
      r_tick       <= w_tick_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_div_active_next = r_div_active;
    w_pend_val_next   = r_pend_val;
    w_pending_next    = r_pending;
    w_out_next        = r_out;
    w_tick_next       = 1'b0;

    case (r_state)
      ST_STOP: begin
        w_cnt_next = '0;
        w_out_next = 1'b0;
        // A ratio accepted on the very edge that ended the last period can
        // be left pending; apply it now so the port does not stay blocked.
        if (r_pending) begin
          w_div_active_next = r_pend_val;
          w_pending_next    = 1'b0;
        end else if (w_xfer) begin
          w_div_active_next = w_div_clamped;
        end
        if (i_en) begin
          w_state_next = ST_RUN;
          w_out_next   = 1'b1;
          w_tick_next  = 1'b1;
        end
      end

      ST_RUN: begin
        if (w_boundary) begin
          if (r_pending) begin
            w_div_active_next = r_pend_val;
            w_pending_next    = 1'b0;
          end
          w_cnt_next = '0;
          if (i_en) begin
            w_out_next  = 1'b1;
            w_tick_next = 1'b1;
          end else begin
            w_state_next = ST_STOP;
            w_out_next   = 1'b0;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
          w_out_next = ({1'b0, w_cnt_inc} < w_half);
        end
        // Transfers only happen with nothing pending, so this never collides
        // with the boundary consuming the pending slot above.
        if (w_xfer) begin
          w_pending_next  = 1'b1;
          w_pend_val_next = w_div_clamped;
        end
      end

      default: begin
        w_state_next = ST_STOP;
      end
    endcase
  end

  assign o_div_ready  = !r_pending;
  assign o_div_active = r_div_active;
  assign o_out        = r_out;
  assign o_tick       = r_tick;

endmodule

// File: tb/tb_adam_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_adam_clk_div_prog
//   Directed bench for adam_clk_div_prog (WIDTH=8, RESET_DIV=2). Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adam_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;
  logic       div_valid = 1'b0;
  logic       div_ready;
  logic [7:0] div_active;
  logic       out_clk;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  adam_clk_div_prog #(
    .WIDTH    (8),
    .RESET_DIV(2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_div       (div),
    .i_div_valid (div_valid),
    .o_div_ready (div_ready),
    .o_div_active(div_active),
    .o_out       (out_clk),
    .o_tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check out/tick for the current cycle, then advance to the next sample point.
  task automatic chk_step(input string tag, input logic exp_out, input logic exp_tick);
    check({tag, " out"}, 32'(out_clk), 32'(exp_out));
    check({tag, " tick"}, 32'(tick), 32'(exp_tick));
    @(negedge clk);
  endtask

  // Check whole periods of ratio e with h high cycles, starting at cnt=0.
  task automatic run_expect(input string tag, input int e, input int h, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < e; c++) begin
        chk_step($sformatf("%s p%0d c%0d", tag, p, c), (c < h), (c == 0));
      end
    end
  endtask

  // Load a ratio while stopped; it reaches div_active at the transfer edge.
  task automatic load_stopped(input logic [7:0] d);
    div       = d;
    div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
  endtask

  // From STOP: load d, run 'periods' periods with en high, one more with en
  // dropped at its start, then confirm the divider has stopped.
  task automatic run_ratio(input string tag, input logic [7:0] d, input int e, input int h,
                           input int periods);
    load_stopped(d);
    check({tag, " active"}, 32'(div_active), 32'(e));
    check({tag, " ready"}, 32'(div_ready), 32'd1);
    en = 1'b1;
    chk_step({tag, " pre"}, 1'b0, 1'b0);
    run_expect(tag, e, h, periods);
    en = 1'b0;
    run_expect({tag, " last"}, e, h, 1);
    chk_step({tag, " stopped"}, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values, visible without any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst out", 32'(out_clk), 32'd0);
    check("rst tick", 32'(tick), 32'd0);
    check("rst ready", 32'(div_ready), 32'd1);
    check("rst active", 32'(div_active), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    chk_step("idle", 1'b0, 1'b0);

    // Even ratio D=4: rise one cycle after en, then 1100 repeating.
    load_stopped(8'd4);
    check("d4 active", 32'(div_active), 32'd4);
    en = 1'b1;
    chk_step("d4 pre", 1'b0, 1'b0);
    run_expect("d4", 4, 2, 2);

    // Runtime change to 6 at cnt=1; a second request while pending stalls.
    chk_step("chg c0", 1'b1, 1'b1);
    div = 8'd6;
    div_valid = 1'b1;
    check("chg ready c1", 32'(div_ready), 32'd1);
    chk_step("chg c1", 1'b1, 1'b0);
    div = 8'd9;
    check("chg ready c2", 32'(div_ready), 32'd0);
    check("chg active c2", 32'(div_active), 32'd4);
    chk_step("chg c2", 1'b0, 1'b0);
    check("chg ready c3", 32'(div_ready), 32'd0);
    chk_step("chg c3", 1'b0, 1'b0);
    div_valid = 1'b0;
    check("chg active new", 32'(div_active), 32'd6);
    check("chg ready new", 32'(div_ready), 32'd1);
    run_expect("d6", 6, 3, 1);
    check("stall no overwrite", 32'(div_active), 32'd6);

    // Graceful stop: en low at cnt=1, the period completes, then STOP.
    chk_step("stop c0", 1'b1, 1'b1);
    en = 1'b0;
    chk_step("stop c1", 1'b1, 1'b0);
    chk_step("stop c2", 1'b1, 1'b0);
    chk_step("stop c3", 1'b0, 1'b0);
    chk_step("stop c4", 1'b0, 1'b0);
    chk_step("stop c5", 1'b0, 1'b0);
    chk_step("stopped a", 1'b0, 1'b0);
    chk_step("stopped b", 1'b0, 1'b0);
    en = 1'b1;
    chk_step("restart pre", 1'b0, 1'b0);
    // Drop en at cnt=1, re-assert at cnt=3: seamless continue.
    chk_step("cont c0", 1'b1, 1'b1);
    en = 1'b0;
    chk_step("cont c1", 1'b1, 1'b0);
    chk_step("cont c2", 1'b1, 1'b0);
    en = 1'b1;
    chk_step("cont c3", 1'b0, 1'b0);
    chk_step("cont c4", 1'b0, 1'b0);
    chk_step("cont c5", 1'b0, 1'b0);
    run_expect("cont next", 6, 3, 1);
    en = 1'b0;
    run_expect("d6 last", 6, 3, 1);
    chk_step("d6 stopped", 1'b0, 1'b0);

    // Odd ratio, clamps and the maximum ratio.
    run_ratio("d5", 8'd5, 5, 3, 1);
    run_ratio("d1", 8'd1, 2, 1, 2);
    run_ratio("d0", 8'd0, 2, 1, 2);
    run_ratio("d255", 8'd255, 255, 128, 0);

    // Async reset at cnt=2 of D=6, then restart at RESET_DIV=2.
    load_stopped(8'd6);
    check("rr active", 32'(div_active), 32'd6);
    en = 1'b1;
    chk_step("rr pre", 1'b0, 1'b0);
    chk_step("rr c0", 1'b1, 1'b1);
    chk_step("rr c1", 1'b1, 1'b0);
    check("rr c2 out", 32'(out_clk), 32'd1);
    rst = 1'b1;
    #1;
    check("rr async out", 32'(out_clk), 32'd0);
    check("rr async tick", 32'(tick), 32'd0);
    check("rr async ready", 32'(div_ready), 32'd1);
    check("rr async active", 32'(div_active), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    chk_step("rr rel", 1'b0, 1'b0);
    run_expect("rr d2", 2, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
